ex_mem_pipe_reg: RTL and testbench
==================================

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of ALU result and store data.
REQ-002 SHALL have parameter RD_WIDTH, default 5, width of destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  synchronous flush of all held entries.
REQ-006 SHALL have port ex_valid_i  input  1  EX stage presents a valid instruction.
REQ-007 SHALL have port ex_ready_o  output  1  block can accept an instruction this cycle.
REQ-008 SHALL have port alu_result_i  input  DATA_WIDTH  ALU result from EX.
REQ-009 SHALL have port zero_i  input  1  ALU zero flag from EX.
REQ-010 SHALL have port store_data_i  input  DATA_WIDTH  rs2 value for stores.
REQ-011 SHALL have port rd_i  input  RD_WIDTH  destination register index.
REQ-012 SHALL have ports reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  input  1 each  control bits.
REQ-013 SHALL have port mem_valid_o  output  1  MEM stage receives a valid instruction.
REQ-014 SHALL have port mem_ready_i  input  1  MEM stage accepts this cycle.
REQ-015 SHALL have outputs alu_result_o, zero_o, store_data_o, rd_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, widths matching inputs.

Function
REQ-016 SHALL define accept = ex_valid_i & ex_ready_o and issue = mem_valid_o & mem_ready_i.
REQ-017 SHALL hold up to two entries: main (drives outputs) and skid; states EMPTY, ONE, FULL.
REQ-018 SHALL drive ex_ready_o = 1 in EMPTY and ONE, 0 in FULL, from registered state only (no combinational path from mem_ready_i).
REQ-019 SHALL drive mem_valid_o = 1 in ONE and FULL, 0 in EMPTY.
REQ-020 EMPTY: accept -> ONE, incoming loaded into main; else stay.
REQ-021 ONE: accept & issue -> ONE, main reloaded with incoming; accept & !issue -> FULL, incoming into skid; !accept & issue -> EMPTY; neither -> hold.
REQ-022 FULL: issue -> ONE, skid moves into main; !issue -> hold; no accept possible.
REQ-023 SHALL preserve strict FIFO order; no entry lost or duplicated.
REQ-024 SHALL have one-cycle latency: entry accepted at edge N appears on outputs after edge N when main was empty or issued at N.
REQ-025 SHALL force reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o to 0 whenever mem_valid_o = 0 (bubble); data outputs hold last main value.
REQ-026 SHALL pass all data fields bit-exact, no sign or width change.
REQ-027 flush_i = 1 at an edge SHALL move to EMPTY, clearing both entries' control bits; flush overrides accept and issue in the same cycle (incoming instruction discarded).
REQ-028 SHALL keep entry contents stable while mem_valid_o = 1 and mem_ready_i = 0.

Reset
REQ-029 reset = 0 SHALL immediately (asynchronously) force state EMPTY, mem_valid_o = 0, ex_ready_o = 1, all control outputs 0.
REQ-030 reset = 0 SHALL clear alu_result_o, store_data_o, rd_o, zero_o and skid contents to 0.
REQ-031 reset asserted mid-transfer SHALL discard both entries; first accept after release SHALL occur no earlier than the first rising edge with reset = 1.

Verification
REQ-032 Stream: mem_ready_i = 1, ex_valid_i = 1 for alu_result_i = 1,2,3,4 on consecutive cycles -> outputs 1,2,3,4 on consecutive cycles, ex_ready_o stays 1.
REQ-033 Backpressure: accept 0x10, 0x20 with mem_ready_i = 0 -> state FULL, ex_ready_o = 0, alu_result_o = 0x10 held; raise mem_ready_i -> 0x10 then 0x20 issued, ex_ready_o = 1 one cycle after first issue.
REQ-034 Bubble: ex_valid_i = 0 with reg_write_i = 1, mem_write_i = 1 -> mem_valid_o = 0, reg_write_o = 0, mem_write_o = 0.
REQ-035 Flush: FULL with 0xA, 0xB, flush_i = 1 together with ex_valid_i = 1 (0xC) -> next cycle mem_valid_o = 0, 0xA/0xB/0xC never issued.
REQ-036 Reset mid-operation: state ONE with rd_i = 7, reg_write_i = 1, pulse reset low between edges -> mem_valid_o = 0, rd_o = 0, reg_write_o = 0 before next edge.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
//
// EX -> MEM pipeline register with a two-entry skid buffer. The "main"
// entry drives the MEM-side outputs. The "skid" entry catches one
// instruction accepted while MEM is stalling. ex_ready_o depends only on
// registered state, so there is no combinational path from mem_ready_i
// back to the EX stage.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   flush_i           synchronous flush; drops both held entries and any
//                     incoming instruction in the same cycle
//   ex_valid_i        EX presents an instruction
//   ex_ready_o        this block can accept an instruction
//   alu_result_i, zero_i, store_data_i, rd_i,
//   reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i
//                     EX-stage payload
//   mem_valid_o       MEM receives a valid instruction
//   mem_ready_i       MEM accepts this cycle
//   alu_result_o, zero_o, store_data_o, rd_o,
//   reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o
//                     main-entry payload; control bits are gated to 0
//                     while mem_valid_o is low
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_i,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  zero_i,
   input  logic [DATA_WIDTH-1:0] store_data_i,
   input  logic [RD_WIDTH-1:0]   rd_i,
   input  logic                  reg_write_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic                  mem_to_reg_i,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [DATA_WIDTH-1:0] alu_result_o,
   output logic                  zero_o,
   output logic [DATA_WIDTH-1:0] store_data_o,
   output logic [RD_WIDTH-1:0]   rd_o,
   output logic                  reg_write_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic                  mem_to_reg_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] alu_result;
      logic                  zero;
      logic [DATA_WIDTH-1:0] store_data;
      logic [RD_WIDTH-1:0]   rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
   } entry_t;

   state_t state, state_nxt;
   entry_t main_q, skid_q, in_entry;

   logic accept, issue;
   logic load_main_in, load_main_skid, load_skid;

   // Drops the control bits of an entry; data fields are left untouched.
   function automatic entry_t clear_ctl(input entry_t e);
      entry_t r;
      r            = e;
      r.reg_write  = 1'b0;
      r.mem_read   = 1'b0;
      r.mem_write  = 1'b0;
      r.mem_to_reg = 1'b0;
      return r;
   endfunction

   assign in_entry = '{alu_result: alu_result_i, zero: zero_i,
                       store_data: store_data_i, rd: rd_i,
                       reg_write: reg_write_i, mem_read: mem_read_i,
                       mem_write: mem_write_i, mem_to_reg: mem_to_reg_i};

   assign ex_ready_o  = (state != S_FULL);
   assign mem_valid_o = (state != S_EMPTY);
   assign accept      = ex_valid_i & ex_ready_o;
   assign issue       = mem_valid_o & mem_ready_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               state_nxt    = S_ONE;
               load_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (accept && issue) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_nxt = S_FULL;
               load_skid = 1'b1;
            end else if (issue) begin
               state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (issue) begin
               state_nxt      = S_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
      // Flush wins over everything; the incoming instruction is dropped.
      if (flush_i) begin
         state_nxt      = S_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (flush_i) begin
         main_q <= clear_ctl(main_q);
         skid_q <= clear_ctl(skid_q);
      end else begin
         if (load_main_in) begin
            main_q <= in_entry;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   assign alu_result_o = main_q.alu_result;
   assign zero_o       = main_q.zero;
   assign store_data_o = main_q.store_data;
   assign rd_o         = main_q.rd;

   // Bubbles carry no side effects into MEM.
   assign reg_write_o  = main_q.reg_write  & mem_valid_o;
   assign mem_read_o   = main_q.mem_read   & mem_valid_o;
   assign mem_write_o  = main_q.mem_write  & mem_valid_o;
   assign mem_to_reg_o = main_q.mem_to_reg & mem_valid_o;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
//
// Self-checking bench for ex_mem_pipe_reg. A queue-based FIFO model of
// capacity two predicts readiness, validity and the payload at the head
// of the queue. Directed scenarios cover streaming, backpressure, bubbles,
// flush and asynchronous reset. Random traffic follows them.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

   localparam int DW = 32;
   localparam int RW = 5;

   typedef struct packed {
      logic [DW-1:0] alu;
      logic          zero;
      logic [DW-1:0] sd;
      logic [RW-1:0] rd;
      logic          rw;
      logic          mr;
      logic          mw;
      logic          m2r;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_i;
   logic          ex_valid_i;
   logic          ex_ready_o;
   logic [DW-1:0] alu_result_i;
   logic          zero_i;
   logic [DW-1:0] store_data_i;
   logic [RW-1:0] rd_i;
   logic          reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
   logic          mem_valid_o;
   logic          mem_ready_i;
   logic [DW-1:0] alu_result_o;
   logic          zero_o;
   logic [DW-1:0] store_data_o;
   logic [RW-1:0] rd_o;
   logic          reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;

   ex_mem_pipe_reg #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
      .alu_result_i(alu_result_i), .zero_i(zero_i),
      .store_data_i(store_data_i), .rd_i(rd_i),
      .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
      .alu_result_o(alu_result_o), .zero_o(zero_o),
      .store_data_o(store_data_o), .rd_o(rd_o),
      .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
      .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO of accepted-but-not-issued instructions, plus
   // the payload last seen at the head (data outputs hold it when empty).
   ent_t q[$];
   ent_t last_head;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   issued_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic ent_t cur_in();
      ent_t e;
      e.alu = alu_result_i; e.zero = zero_i; e.sd = store_data_i; e.rd = rd_i;
      e.rw = reg_write_i; e.mr = mem_read_i; e.mw = mem_write_i; e.m2r = mem_to_reg_i;
      return e;
   endfunction

   task automatic check_outputs(input string tag);
      ent_t e;
      logic v;
      v = (q.size() > 0);
      e = v ? q[0] : last_head;
      check({tag, "_rdy"},  64'(ex_ready_o),   64'(q.size() < 2));
      check({tag, "_vld"},  64'(mem_valid_o),  64'(v));
      check({tag, "_alu"},  64'(alu_result_o), 64'(e.alu));
      check({tag, "_zero"}, 64'(zero_o),       64'(e.zero));
      check({tag, "_sd"},   64'(store_data_o), 64'(e.sd));
      check({tag, "_rd"},   64'(rd_o),         64'(e.rd));
      check({tag, "_ctl"},  64'({reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}),
            v ? 64'({e.rw, e.mr, e.mw, e.m2r}) : 64'd0);
   endtask

   // Checks the current outputs, advances one clock edge and updates the model.
   task automatic tick(input string tag);
      logic acc, iss, fl;
      ent_t inc;
      check_outputs(tag);
      acc = ex_valid_i && (q.size() < 2);
      iss = (q.size() > 0) && mem_ready_i;
      fl  = flush_i;
      inc = cur_in();
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (iss) begin
            void'(q.pop_front());
            issued_total++;
         end
         if (acc) q.push_back(inc);
      end
      if (q.size() > 0) last_head = q[0];
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] alu, input logic rdy, input logic fl);
      ex_valid_i   = v;
      alu_result_i = alu;
      mem_ready_i  = rdy;
      flush_i      = fl;
      zero_i       = 1'($urandom);
      store_data_i = $urandom;
      rd_i         = RW'($urandom);
      {reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i} = 4'($urandom);
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      last_head = '0;
      #2;
      check_outputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Streaming: one in, one out per cycle.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, DW'(i), 1'b1, 1'b0);
         tick("stream");
         check("stream_rdy", 64'(ex_ready_o), 64'd1);
         check("stream_out", 64'(alu_result_o), 64'(i));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick("drain");

      // Backpressure: fill both entries, then release.
      drive(1'b1, 32'h10, 1'b0, 1'b0); tick("bp0");
      drive(1'b1, 32'h20, 1'b0, 1'b0); tick("bp1");
      drive(1'b0, '0, 1'b0, 1'b0);
      check("bp_full_rdy", 64'(ex_ready_o), 64'd0);
      check("bp_full_alu", 64'(alu_result_o), 64'h10);
      tick("bp_hold");
      check("bp_hold_alu", 64'(alu_result_o), 64'h10);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick("bp_iss0");
      check("bp_second", 64'(alu_result_o), 64'h20);
      check("bp_rdy_back", 64'(ex_ready_o), 64'd1);
      tick("bp_iss1");

      // Bubble: control inputs set but no valid instruction.
      drive(1'b0, 32'h77, 1'b1, 1'b0);
      reg_write_i = 1'b1; mem_write_i = 1'b1;
      tick("bubble");
      check("bubble_vld", 64'(mem_valid_o), 64'd0);
      check("bubble_ctl", 64'({reg_write_o, mem_write_o}), 64'd0);

      // Flush while full together with an incoming instruction.
      drive(1'b1, 32'hA, 1'b0, 1'b0); tick("fl0");
      drive(1'b1, 32'hB, 1'b0, 1'b0); tick("fl1");
      drive(1'b1, 32'hC, 1'b1, 1'b1); tick("fl2");
      check("flush_vld", 64'(mem_valid_o), 64'd0);
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick("post_flush");

      // Asynchronous reset between edges with one entry held.
      drive(1'b1, 32'h55, 1'b0, 1'b0);
      rd_i = 5'd7; reg_write_i = 1'b1;
      tick("pre_rst");
      check("pre_rst_rd", 64'(rd_o), 64'd7);
      drive(1'b1, 32'h66, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("arst_vld", 64'(mem_valid_o), 64'd0);
      check("arst_rd",  64'(rd_o), 64'd0);
      check("arst_rw",  64'(reg_write_o), 64'd0);
      check("arst_rdy", 64'(ex_ready_o), 64'd1);
      q.delete();
      last_head = '0;
      #2 reset = 1'b1;
      tick("post_rst");
      check("post_rst_acc", 64'(alu_result_o), 64'h66);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 20) == 0);
         tick("rand");
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
